// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - constants, FSM encoding and bit-reverse helper shared by the FFT datapath.
package fft_pkg;

  localparam int DATA_WIDTH   = 48;
  localparam int BUFFER_DEPTH = 512;
  localparam int ADDR_WIDTH   = $clog2(BUFFER_DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } loader_state_t;

  function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = a[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bit_reverse.sv
// rtl/fft_bit_reverse.sv - combinational address bit reversal for in-place radix-2 FFT ordering.
module fft_bit_reverse #(
  parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out
);

  for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
    assign addr_out[i] = addr_in[ADDR_WIDTH-1-i];
  end

endmodule

// File: rtl/fft_input_loader.sv
// rtl/fft_input_loader.sv - loads a frame of real samples into FFT RAM at bit-reversed addresses, then starts the core.
// Optional FFT_LOADER_OVERRUN_CNT_EN adds a saturating dropped-sample counter o_overrun_cnt.
module fft_input_loader #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int DATA_WIDTH   = fft_pkg::DATA_WIDTH,
  parameter int BUFFER_DEPTH = fft_pkg::BUFFER_DEPTH,
  parameter int ADDR_WIDTH   = fft_pkg::ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] i_sample_data,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic [ADDR_WIDTH-1:0]   o_addr_a,
  output logic [DATA_WIDTH-1:0]   o_data_a,
  output logic                    o_wr_en_a,
  output logic                    o_fft_start,
  input  logic                    i_fft_done,
  output logic                    o_busy,
  output logic                    o_overrun
`ifdef FFT_LOADER_OVERRUN_CNT_EN
  ,
  output logic [15:0]             o_overrun_cnt
`endif
);

  import fft_pkg::*;

  localparam int HALF = DATA_WIDTH / 2;

  if (SAMPLE_WIDTH > HALF) begin : g_bad_sample_width
    $error("fft_input_loader: SAMPLE_WIDTH exceeds DATA_WIDTH/2");
  end
  if (BUFFER_DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("fft_input_loader: BUFFER_DEPTH must equal 2**ADDR_WIDTH");
  end

  loader_state_t           state;
  loader_state_t           state_next;
  logic [ADDR_WIDTH-1:0]   count;
  logic [ADDR_WIDTH-1:0]   count_rev;
  logic                    accept;
  logic                    drop;
  logic                    last_sample;
  logic signed [HALF-1:0]  real_ext;

  assign o_sample_ready = (state == ST_LOAD);
  assign accept         = i_sample_valid && o_sample_ready;
  assign drop           = i_sample_valid && !o_sample_ready;
  assign last_sample    = (count == ADDR_WIDTH'(BUFFER_DEPTH - 1));
  assign real_ext       = HALF'($signed(i_sample_data));

  fft_bit_reverse #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bit_reverse (
    .addr_in (count),
    .addr_out(count_rev)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:  if (accept && last_sample) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (i_fft_done) state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  // Start is registered from the START state so it lands one cycle after the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      count       <= '0;
      o_addr_a    <= '0;
      o_data_a    <= '0;
      o_wr_en_a   <= 1'b0;
      o_fft_start <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state       <= state_next;
      o_busy      <= (state_next != ST_LOAD);
      o_wr_en_a   <= accept;
      o_fft_start <= (state == ST_START);
      if (accept) begin
        o_addr_a <= count_rev;
        o_data_a <= {real_ext, {HALF{1'b0}}};
        count    <= count + 1'b1;
      end
      if (drop) begin
        o_overrun <= 1'b1;
      end
    end
  end

`ifdef FFT_LOADER_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun_cnt <= '0;
    end else if (drop && (o_overrun_cnt != 16'hFFFF)) begin
      o_overrun_cnt <= o_overrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_input_loader.sv
// tb/tb_fft_input_loader.sv - directed self-checking bench for fft_input_loader.
module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] i_sample_data = '0;
  logic        i_sample_valid = 1'b0;
  logic        o_sample_ready;
  logic [8:0]  o_addr_a;
  logic [47:0] o_data_a;
  logic        o_wr_en_a;
  logic        o_fft_start;
  logic        i_fft_done = 1'b0;
  logic        o_busy;
  logic        o_overrun;

  logic [15:0] s16_data = '0;
  logic        s16_valid = 1'b0;
  logic        s16_ready;
  logic [8:0]  s16_addr;
  logic [47:0] s16_wdata;
  logic        s16_wr_en;
  logic        s16_start;
  logic        s16_busy;
  logic        s16_overrun;

`ifdef FFT_LOADER_OVERRUN_CNT_EN
  logic [15:0] o_overrun_cnt;
  logic [15:0] s16_overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_input_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sample_data (i_sample_data),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_addr_a      (o_addr_a),
    .o_data_a      (o_data_a),
    .o_wr_en_a     (o_wr_en_a),
    .o_fft_start   (o_fft_start),
    .i_fft_done    (i_fft_done),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
`ifdef FFT_LOADER_OVERRUN_CNT_EN
    ,
    .o_overrun_cnt (o_overrun_cnt)
`endif
  );

  fft_input_loader #(.SAMPLE_WIDTH(16)) dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sample_data (s16_data),
    .i_sample_valid(s16_valid),
    .o_sample_ready(s16_ready),
    .o_addr_a      (s16_addr),
    .o_data_a      (s16_wdata),
    .o_wr_en_a     (s16_wr_en),
    .o_fft_start   (s16_start),
    .i_fft_done    (1'b0),
    .o_busy        (s16_busy),
    .o_overrun     (s16_overrun)
`ifdef FFT_LOADER_OVERRUN_CNT_EN
    ,
    .o_overrun_cnt (s16_overrun_cnt)
`endif
  );

  function automatic logic [8:0] rev9(input logic [8:0] a);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = a[8-i];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step;
    step;
    checks++;
    if ({o_addr_a, o_data_a, o_wr_en_a, o_fft_start, o_busy, o_overrun} !== '0)
      begin errors++; $display("FAIL reset_outputs: got addr=%h data=%h we=%b st=%b busy=%b ovr=%b, want all 0",
                               o_addr_a, o_data_a, o_wr_en_a, o_fft_start, o_busy, o_overrun); end
    checks++;
    if (o_sample_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready: got %b want 1", o_sample_ready); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic feed_frame(input bit toggle);
    logic [8:0]  exp_addr;
    logic [47:0] exp_data;
    for (int k = 0; k < 512; k++) begin
      if (toggle) begin
        i_sample_valid = 1'b0;
        step;
        checks++;
        if (o_wr_en_a !== 1'b0 || o_fft_start !== 1'b0)
          begin errors++; $display("FAIL idle_no_write k=%0d: we=%b st=%b want 0 0", k, o_wr_en_a, o_fft_start); end
      end
      i_sample_valid = 1'b1;
      i_sample_data  = 24'(k);
      step;
      exp_addr = rev9(9'(k));
      exp_data = {24'(k), 24'h0};
      checks++;
      if ({o_wr_en_a, o_addr_a, o_data_a, o_fft_start} !== {1'b1, exp_addr, exp_data, 1'b0})
        begin errors++; $display("FAIL frame_write k=%0d: we=%b addr=%0d data=%h st=%b want 1 %0d %h 0",
                                 k, o_wr_en_a, o_addr_a, o_data_a, o_fft_start, exp_addr, exp_data); end
      if (k == 1) begin
        checks++;
        if (o_addr_a !== 9'd256 || o_data_a !== 48'h000001_000000)
          begin errors++; $display("FAIL sample1: addr=%0d data=%h want 256 000001000000", o_addr_a, o_data_a); end
      end
      if (k == 2) begin
        checks++;
        if (o_addr_a !== 9'd128)
          begin errors++; $display("FAIL sample2_addr: got %0d want 128", o_addr_a); end
      end
      if (k == 511) begin
        checks++;
        if (o_addr_a !== 9'd511 || o_busy !== 1'b1)
          begin errors++; $display("FAIL sample511: addr=%0d busy=%b want 511 1", o_addr_a, o_busy); end
      end
    end
    i_sample_valid = 1'b0;
    step;
    checks++;
    if (o_fft_start !== 1'b1 || o_wr_en_a !== 1'b0)
      begin errors++; $display("FAIL start_pulse: st=%b we=%b want 1 0", o_fft_start, o_wr_en_a); end
    step;
    checks++;
    if (o_fft_start !== 1'b0 || o_busy !== 1'b1 || o_sample_ready !== 1'b0)
      begin errors++; $display("FAIL start_single: st=%b busy=%b rdy=%b want 0 1 0", o_fft_start, o_busy, o_sample_ready); end
  endtask

  task automatic test_overrun;
    for (int k = 0; k < 3; k++) begin
      i_sample_valid = 1'b1;
      i_sample_data  = 24'h123456;
      #1;
      checks++;
      if (o_sample_ready !== 1'b0)
        begin errors++; $display("FAIL wait_ready k=%0d: got %b want 0", k, o_sample_ready); end
      step;
      checks++;
      if (o_wr_en_a !== 1'b0)
        begin errors++; $display("FAIL wait_no_write k=%0d: got %b want 0", k, o_wr_en_a); end
    end
    i_sample_valid = 1'b0;
    step;
    checks++;
    if (o_overrun !== 1'b1)
      begin errors++; $display("FAIL overrun_flag: got %b want 1", o_overrun); end
`ifdef FFT_LOADER_OVERRUN_CNT_EN
    checks++;
    if (o_overrun_cnt !== 16'd3)
      begin errors++; $display("FAIL overrun_cnt: got %0d want 3", o_overrun_cnt); end
`endif
  endtask

  task automatic test_done;
    i_fft_done = 1'b1;
    step;
    i_fft_done = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_sample_ready !== 1'b1)
      begin errors++; $display("FAIL done_release: busy=%b rdy=%b want 0 1", o_busy, o_sample_ready); end
  endtask

  task automatic test_negative;
    i_sample_valid = 1'b1;
    i_sample_data  = 24'h800000;
    s16_valid      = 1'b1;
    s16_data       = 16'h8000;
    step;
    i_sample_valid = 1'b0;
    s16_valid      = 1'b0;
    checks++;
    if (o_wr_en_a !== 1'b1 || o_addr_a !== 9'd0 || o_data_a !== 48'h800000_000000)
      begin errors++; $display("FAIL neg24: we=%b addr=%0d data=%h want 1 0 800000000000", o_wr_en_a, o_addr_a, o_data_a); end
    checks++;
    if (s16_wr_en !== 1'b1 || s16_addr !== 9'd0 || s16_wdata !== 48'hFF8000_000000)
      begin errors++; $display("FAIL neg16_sext: we=%b addr=%0d data=%h want 1 0 ff8000000000", s16_wr_en, s16_addr, s16_wdata); end
  endtask

  task automatic test_reset_midframe;
    for (int k = 1; k < 100; k++) begin
      i_sample_valid = 1'b1;
      i_sample_data  = 24'(k + 7);
      step;
    end
    checks++;
    if (o_wr_en_a !== 1'b1 || o_addr_a !== rev9(9'd99))
      begin errors++; $display("FAIL pre_reset_write: we=%b addr=%0d want 1 %0d", o_wr_en_a, o_addr_a, rev9(9'd99)); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_addr_a, o_data_a, o_wr_en_a, o_fft_start, o_busy, o_overrun} !== '0)
      begin errors++; $display("FAIL async_reset: addr=%h data=%h we=%b st=%b busy=%b ovr=%b want all 0",
                               o_addr_a, o_data_a, o_wr_en_a, o_fft_start, o_busy, o_overrun); end
    i_sample_valid = 1'b0;
    step;
    rst_n = 1'b1;
    step;
  endtask

  initial begin
    test_reset;
    feed_frame(1'b0);
    test_overrun;
    test_done;
    test_negative;
    test_reset_midframe;
    feed_frame(1'b0);
    test_done;
    feed_frame(1'b1);
    test_done;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
